// File: rtl/microsequencer_pkg.sv
// Shared opcodes and sizing helpers for the microprogram sequencer.
// Opcode numbering follows the Am2910 instruction set.
package microsequencer_pkg;

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/microsequencer_stack.sv
// Subroutine/loop LIFO: a push when full overwrites the last entry,
// a pop when empty does nothing, TOP reads 0 when empty.
module microsequencer_stack
  import microsequencer_pkg::*;
#(
  parameter int AW    = 11,
  parameter int DEPTH = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int SW = sp_width(DEPTH);
  localparam logic [SW-1:0] MAX  = SW'(DEPTH);
  localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

  logic [AW-1:0] mem [DEPTH];
  logic [SW-1:0] sp;

  assign full  = sp == MAX;
  assign empty = sp == '0;
  assign top   = empty ? '0 : mem[sp - 1'b1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push) begin
      if (full) begin
        mem[LAST] <= din;
      end else begin
        mem[sp] <= din;
        sp      <= sp + 1'b1;
      end
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Am2910-style microprogram sequencer: next-address mux, uPC,
// loop counter R and subroutine stack feeding the microcode ROM.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int AW    = 11,
  parameter int DEPTH = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    instr,
  input  logic          cc,
  input  logic          ccen,
  input  logic [AW-1:0] d,
  input  logic          ld_r,
  input  logic          ci,
  output logic [AW-1:0] y,
  output logic          pl_en,
  output logic          map_en,
  output logic          vect_en,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] upc;
  logic [AW-1:0] r;
  logic [AW-1:0] top;
  logic [15:0]   op;
  logic          pass;
  logic          r0;
  logic          push;
  logic          pop;
  logic          clear;
  logic          r_load;
  logic          r_dec;

  assign pass = ~ccen | cc;
  assign r0   = r == '0;
  assign op   = 16'(1) << instr;

  always_comb begin
    y       = upc;
    pl_en   = 1'b1;
    map_en  = 1'b0;
    vect_en = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    r_load  = 1'b0;
    r_dec   = 1'b0;
    unique case (1'b1)
      op[OP_JZ]: begin
        y     = '0;
        clear = 1'b1;
      end
      op[OP_CJS]: if (pass) begin
        y    = d;
        push = 1'b1;
      end
      op[OP_JMAP]: begin
        y      = d;
        pl_en  = 1'b0;
        map_en = 1'b1;
      end
      op[OP_CJP]: if (pass) y = d;
      op[OP_PUSH]: begin
        push   = 1'b1;
        r_load = pass;
      end
      op[OP_JSRP]: begin
        push = 1'b1;
        y    = pass ? d : r;
      end
      op[OP_CJV]: begin
        y       = pass ? d : upc;
        pl_en   = 1'b0;
        vect_en = 1'b1;
      end
      op[OP_JRP]: y = pass ? d : r;
      op[OP_RFCT]: begin
        if (!r0) begin
          y     = top;
          r_dec = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      op[OP_RPCT]: if (!r0) begin
        y     = d;
        r_dec = 1'b1;
      end
      op[OP_CRTN]: if (pass) begin
        y   = top;
        pop = 1'b1;
      end
      op[OP_CJPP]: if (pass) begin
        y   = d;
        pop = 1'b1;
      end
      op[OP_LDCT]: r_load = 1'b1;
      op[OP_LOOP]: begin
        if (pass) pop = 1'b1;
        else y = top;
      end
      op[OP_CONT]: ;
      op[OP_TWB]: begin
        // Exhausted count always pops; otherwise only a pass exits
        pop   = r0 | pass;
        r_dec = !r0;
        if (r0) y = pass ? upc : d;
        else if (!pass) y = top;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upc <= '0;
      r   <= '0;
    end else begin
      upc <= y + AW'(ci);
      if (ld_r || r_load) r <= d;
      else if (r_dec) r <= r - 1'b1;
    end
  end

  microsequencer_stack #(
    .AW   (AW),
    .DEPTH(DEPTH)
  ) u_stack (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .clear(clear),
    .din  (upc),
    .top  (top),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench: directed scenario tables plus random vectors,
// all compared against a queue-based sequencer model.
module tb_microsequencer;
  import microsequencer_pkg::*;

  localparam int AW    = 11;
  localparam int DEPTH = 5;
  localparam logic [2:0] PL = 3'b100;
  localparam logic [2:0] MP = 3'b010;
  localparam logic [2:0] VC = 3'b001;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    instr = OP_CONT;
  logic          cc    = 1'b0;
  logic          ccen  = 1'b1;
  logic [AW-1:0] d     = '0;
  logic          ld_r  = 1'b0;
  logic          ci    = 1'b1;
  logic [AW-1:0] y;
  logic          pl_en;
  logic          map_en;
  logic          vect_en;
  logic          full;
  logic          empty;

  microsequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .instr  (instr),
    .cc     (cc),
    .ccen   (ccen),
    .d      (d),
    .ld_r   (ld_r),
    .ci     (ci),
    .y      (y),
    .pl_en  (pl_en),
    .map_en (map_en),
    .vect_en(vect_en),
    .full   (full),
    .empty  (empty)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [AW-1:0] m_upc;
  logic [AW-1:0] m_r;
  logic [AW-1:0] m_stk[$];
  logic [AW-1:0] e_y;
  logic [2:0]    e_sel;
  bit e_push, e_pop, e_clr, e_ld, e_dec;
  logic [15:0] got, exp;

  function automatic logic [32:0] v(
    input logic [3:0] i, input logic c, input logic ce,
    input logic [10:0] dd, input logic l, input logic cin,
    input logic [10:0] wy, input logic [2:0] ws);
    return {i, c, ce, dd, l, cin, wy, ws};
  endfunction

  function automatic logic [AW-1:0] m_top();
    if (m_stk.size() == 0) return '0;
    return m_stk[m_stk.size() - 1];
  endfunction

  task automatic m_reset();
    m_upc = '0;
    m_r   = '0;
    m_stk.delete();
  endtask

  task automatic m_eval();
    bit p;
    bit z;
    p = !ccen || cc;
    z = (m_r == 0);
    e_y = m_upc;
    e_sel = PL;
    e_push = 0; e_pop = 0; e_clr = 0; e_ld = 0; e_dec = 0;
    case (instr)
      OP_JZ:   begin e_y = '0; e_clr = 1; end
      OP_CJS:  if (p) begin e_y = d; e_push = 1; end
      OP_JMAP: begin e_y = d; e_sel = MP; end
      OP_CJP:  if (p) e_y = d;
      OP_PUSH: begin e_push = 1; e_ld = p; end
      OP_JSRP: begin e_push = 1; e_y = p ? d : m_r; end
      OP_CJV:  begin e_y = p ? d : m_upc; e_sel = VC; end
      OP_JRP:  e_y = p ? d : m_r;
      OP_RFCT: if (z) e_pop = 1;
               else begin e_y = m_top(); e_dec = 1; end
      OP_RPCT: if (!z) begin e_y = d; e_dec = 1; end
      OP_CRTN: if (p) begin e_y = m_top(); e_pop = 1; end
      OP_CJPP: if (p) begin e_y = d; e_pop = 1; end
      OP_LDCT: e_ld = 1;
      OP_LOOP: if (p) e_pop = 1; else e_y = m_top();
      OP_TWB: begin
        if (z) begin
          e_pop = 1;
          if (!p) e_y = d;
        end else begin
          e_dec = 1;
          if (p) e_pop = 1; else e_y = m_top();
        end
      end
      default: ;
    endcase
  endtask

  task automatic m_commit();
    if (e_clr) m_stk.delete();
    else if (e_push) begin
      if (m_stk.size() == DEPTH) m_stk[DEPTH-1] = m_upc;
      else m_stk.push_back(m_upc);
    end else if (e_pop && m_stk.size() > 0) begin
      void'(m_stk.pop_back());
    end
    if (ld_r || e_ld) m_r = d;
    else if (e_dec && m_r != 0) m_r = m_r - 11'd1;
    m_upc = e_y + AW'(ci);
  endtask

  task automatic drive(input logic [32:0] t);
    @(negedge clock);
    {instr, cc, ccen, d, ld_r, ci} = t[32:14];
    m_eval();
    #1;
    got = {y, pl_en, map_en, vect_en, full, empty};
    exp = {e_y, e_sel, m_stk.size() == DEPTH, m_stk.size() == 0};
  endtask

  task automatic tick();
    @(posedge clock);
    m_commit();
  endtask

  task automatic test_reset();
    logic [32:0] t[$];
    reset = 1'b0;
    {instr, cc, ccen, d, ld_r, ci} = {OP_CONT, L, H, 11'h0, L, H};
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    n_vec++;
    if ({y, full, empty} !== {11'h000, L, H}) begin
      n_bad++;
      $display("FAIL reset_hold: got y=%h full=%b empty=%b want y=000 full=0 empty=1",
               y, full, empty);
    end
    @(posedge clock);
    #2;
    reset = 1'b1;
    m_reset();
    for (int k = 0; k < 4; k++)
      t.push_back(v(OP_CONT, L, H, 11'h0, L, H, 11'(k), PL));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset[%0d] model: got %h want %h", k, got, exp);
      end
      n_vec++;
      if ({y, pl_en, map_en, vect_en} !== t[k][13:0]) begin
        n_bad++;
        $display("FAIL reset[%0d] table: got %h want %h", k,
                 {y, pl_en, map_en, vect_en}, t[k][13:0]);
      end
      tick();
    end
  endtask

  task automatic test_subroutine();
    logic [32:0] t[$];
    t.push_back(v(OP_CJP,  H, H, 11'h00F, L, H, 11'h00F, PL));
    t.push_back(v(OP_CJS,  H, H, 11'h200, L, H, 11'h200, PL));
    t.push_back(v(OP_CONT, L, H, 11'h000, L, H, 11'h201, PL));
    t.push_back(v(OP_CONT, L, H, 11'h000, L, H, 11'h202, PL));
    t.push_back(v(OP_CRTN, H, H, 11'h000, L, L, 11'h010, PL));
    t.push_back(v(OP_CJS,  L, H, 11'h200, L, H, 11'h010, PL));
    t.push_back(v(OP_CJP,  L, L, 11'h055, L, H, 11'h055, PL));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL sub[%0d] model: got %h want %h", k, got, exp);
      end
      n_vec++;
      if ({y, pl_en, map_en, vect_en} !== t[k][13:0]) begin
        n_bad++;
        $display("FAIL sub[%0d] table: got %h want %h", k,
                 {y, pl_en, map_en, vect_en}, t[k][13:0]);
      end
      tick();
    end
  endtask

  task automatic test_loop();
    logic [32:0] t[$];
    t.push_back(v(OP_LDCT, L, H, 11'h003, L, H, 11'h056, PL));
    t.push_back(v(OP_RPCT, L, H, 11'h050, L, H, 11'h050, PL));
    t.push_back(v(OP_RPCT, L, H, 11'h050, L, H, 11'h050, PL));
    t.push_back(v(OP_RPCT, L, H, 11'h050, L, H, 11'h050, PL));
    t.push_back(v(OP_RPCT, L, H, 11'h050, L, H, 11'h051, PL));
    t.push_back(v(OP_LDCT, L, H, 11'h002, L, H, 11'h052, PL));
    t.push_back(v(OP_RPCT, L, H, 11'h007, H, H, 11'h007, PL));
    t.push_back(v(OP_JRP,  L, H, 11'h300, L, H, 11'h007, PL));
    t.push_back(v(OP_JRP,  H, H, 11'h300, L, H, 11'h300, PL));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL loop[%0d] model: got %h want %h", k, got, exp);
      end
      n_vec++;
      if ({y, pl_en, map_en, vect_en} !== t[k][13:0]) begin
        n_bad++;
        $display("FAIL loop[%0d] table: got %h want %h", k,
                 {y, pl_en, map_en, vect_en}, t[k][13:0]);
      end
      tick();
    end
  endtask

  task automatic test_stack();
    logic [32:0] t[$];
    for (int k = 0; k < 6; k++)
      t.push_back(v(OP_PUSH, L, H, 11'h0, L, H, 11'h301 + 11'(k), PL));
    t.push_back(v(OP_CRTN, H, H, 11'h0, L, H, 11'h306, PL));
    t.push_back(v(OP_CRTN, H, H, 11'h0, L, H, 11'h304, PL));
    t.push_back(v(OP_CRTN, H, H, 11'h0, L, H, 11'h303, PL));
    t.push_back(v(OP_CRTN, H, H, 11'h0, L, H, 11'h302, PL));
    t.push_back(v(OP_CRTN, H, H, 11'h0, L, H, 11'h301, PL));
    t.push_back(v(OP_CRTN, H, H, 11'h0, L, H, 11'h000, PL));
    t.push_back(v(OP_CRTN, H, H, 11'h0, L, H, 11'h000, PL));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL stack[%0d] model: got %h want %h", k, got, exp);
      end
      n_vec++;
      if ({y, pl_en, map_en, vect_en} !== t[k][13:0]) begin
        n_bad++;
        $display("FAIL stack[%0d] table: got %h want %h", k,
                 {y, pl_en, map_en, vect_en}, t[k][13:0]);
      end
      if (k == 5) begin
        n_vec++;
        if (full !== 1'b1) begin
          n_bad++;
          $display("FAIL stack_full: got %b want 1", full);
        end
      end
      if (k == 12) begin
        n_vec++;
        if ({full, empty} !== 2'b01) begin
          n_bad++;
          $display("FAIL stack_empty: got %b%b want 01", full, empty);
        end
      end
      tick();
    end
  endtask

  task automatic test_twb();
    logic [32:0] t[$];
    t.push_back(v(OP_CJP,  H, H, 11'h020, L, H, 11'h020, PL));
    t.push_back(v(OP_PUSH, H, H, 11'h002, L, H, 11'h021, PL));
    t.push_back(v(OP_RFCT, L, H, 11'h000, L, H, 11'h021, PL));
    t.push_back(v(OP_RFCT, L, H, 11'h000, L, H, 11'h021, PL));
    t.push_back(v(OP_RFCT, L, H, 11'h000, L, H, 11'h022, PL));
    t.push_back(v(OP_PUSH, L, H, 11'h000, L, H, 11'h023, PL));
    t.push_back(v(OP_TWB,  L, H, 11'h3FF, L, H, 11'h3FF, PL));
    t.push_back(v(OP_LDCT, L, H, 11'h001, L, H, 11'h400, PL));
    t.push_back(v(OP_PUSH, L, H, 11'h000, L, H, 11'h401, PL));
    t.push_back(v(OP_TWB,  L, H, 11'h3FF, L, H, 11'h401, PL));
    t.push_back(v(OP_TWB,  H, H, 11'h3FF, L, H, 11'h402, PL));
    t.push_back(v(OP_PUSH, L, H, 11'h000, L, H, 11'h403, PL));
    t.push_back(v(OP_LOOP, L, H, 11'h000, L, H, 11'h403, PL));
    t.push_back(v(OP_LOOP, H, H, 11'h000, L, H, 11'h404, PL));
    t.push_back(v(OP_PUSH, L, H, 11'h000, L, H, 11'h405, PL));
    t.push_back(v(OP_CJPP, H, H, 11'h123, L, H, 11'h123, PL));
    t.push_back(v(OP_JSRP, L, H, 11'h222, L, H, 11'h000, PL));
    t.push_back(v(OP_JZ,   L, H, 11'h222, L, H, 11'h000, PL));
    t.push_back(v(OP_CRTN, H, H, 11'h000, L, H, 11'h000, PL));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL twb[%0d] model: got %h want %h", k, got, exp);
      end
      n_vec++;
      if ({y, pl_en, map_en, vect_en} !== t[k][13:0]) begin
        n_bad++;
        $display("FAIL twb[%0d] table: got %h want %h", k,
                 {y, pl_en, map_en, vect_en}, t[k][13:0]);
      end
      tick();
    end
  endtask

  task automatic test_dispatch();
    logic [32:0] t[$];
    t.push_back(v(OP_JMAP, L, H, 11'h123, L, H, 11'h123, MP));
    t.push_back(v(OP_CJV,  L, H, 11'h456, L, H, 11'h124, VC));
    t.push_back(v(OP_CJV,  H, H, 11'h456, L, H, 11'h456, VC));
    t.push_back(v(OP_CJP,  H, H, 11'h7FF, L, H, 11'h7FF, PL));
    t.push_back(v(OP_CONT, L, H, 11'h000, L, H, 11'h000, PL));
    t.push_back(v(OP_CONT, L, H, 11'h000, L, L, 11'h001, PL));
    t.push_back(v(OP_CONT, L, H, 11'h000, L, L, 11'h001, PL));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL disp[%0d] model: got %h want %h", k, got, exp);
      end
      n_vec++;
      if ({y, pl_en, map_en, vect_en} !== t[k][13:0]) begin
        n_bad++;
        $display("FAIL disp[%0d] table: got %h want %h", k,
                 {y, pl_en, map_en, vect_en}, t[k][13:0]);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [32:0] t[$];
    logic [32:0] u[$];
    t.push_back(v(OP_LDCT, L, H, 11'h005, L, H, 11'h001, PL));
    t.push_back(v(OP_PUSH, L, H, 11'h000, L, H, 11'h002, PL));
    t.push_back(v(OP_RPCT, L, H, 11'h050, L, H, 11'h050, PL));
    t.push_back(v(OP_RPCT, L, H, 11'h050, L, H, 11'h050, PL));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if ({y, pl_en, map_en, vect_en} !== t[k][13:0]) begin
        n_bad++;
        $display("FAIL arst[%0d] table: got %h want %h", k,
                 {y, pl_en, map_en, vect_en}, t[k][13:0]);
      end
      tick();
    end
    drive(v(OP_RPCT, L, H, 11'h050, L, H, 11'h0, PL));
    n_vec++;
    if (y !== 11'h050) begin
      n_bad++;
      $display("FAIL arst_pre: got y=%h want 050", y);
    end
    #1;
    reset = 1'b0;
    m_reset();
    #1;
    n_vec++;
    if ({y, full, empty} !== {11'h000, L, H}) begin
      n_bad++;
      $display("FAIL arst_now: got y=%h full=%b empty=%b want 000 0 1",
               y, full, empty);
    end
    @(posedge clock);
    #2;
    reset = 1'b1;
    u.push_back(v(OP_JRP,  L, H, 11'h300, L, H, 11'h000, PL));
    u.push_back(v(OP_CRTN, H, H, 11'h000, L, H, 11'h000, PL));
    u.push_back(v(OP_CONT, L, H, 11'h000, L, H, 11'h001, PL));
    foreach (u[k]) begin
      drive(u[k]);
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL arst_post[%0d] model: got %h want %h", k, got, exp);
      end
      n_vec++;
      if ({y, pl_en, map_en, vect_en} !== u[k][13:0]) begin
        n_bad++;
        $display("FAIL arst_post[%0d] table: got %h want %h", k,
                 {y, pl_en, map_en, vect_en}, u[k][13:0]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [32:0] t;
    for (int k = 0; k < 800; k++) begin
      t = v(4'($urandom_range(0, 15)), 1'($urandom),
            $urandom_range(0, 3) != 0, 11'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
            11'h0, 3'b0);
      drive(t);
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL rand[%0d] op=%0d: got %h want %h",
                 k, instr, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_subroutine();
    test_loop();
    test_stack();
    test_twb();
    test_dispatch();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
